uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with configurable word width, parity mode and a first-word-fall-through receive FIFO. It replaces the fixed 8-bit, single-byte-buffer receiver in the I/O system. It sits between the `UART_TXD_IN` pin and the memory-mapped UART read register, and reports parity, framing and overrun errors as sticky flags.

## Interface
- `CLK_RATE`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in bits/s. `BAUD_CLOCKS = CLK_RATE/BAUD_RATE` (integer divide; 868 at defaults).
- `DATA_BITS`, 8, data bits per frame. Legal range 5..9.
- `PARITY_MODE`, 1, parity setting: 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 4, receive FIFO entries. Must be a power of 2, ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_in` in 1: serial input, asynchronous to `clk`, idle high.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `dout` out DATA_BITS: head FIFO entry, valid while `!empty`.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out $clog2(FIFO_DEPTH)+1: number of entries held.
- `parity_err` out 1: sticky, a frame failed its parity check.
- `framing_err` out 1: sticky, the stop bit was sampled low.
- `overrun` out 1: sticky, a good frame was dropped because the FIFO was full.
- `err_clr` in 1: clears all three sticky flags.
- `busy` out 1: receiver is not in IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser. The synchroniser resets to 1.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**: on a synchronised falling edge (previous 1, current 0), load the baud counter with `BAUD_CLOCKS/2` and go to START.
- **START**: when the counter expires, sample the line.
  - Line 0: reload the counter with `BAUD_CLOCKS` and go to DATA.
  - Line 1: treat as a glitch and return to IDLE. No flag is set.
- **DATA**: sample one bit per `BAUD_CLOCKS`, LSB first, into a shift register. After `DATA_BITS` samples, go to PARITY if `PARITY_MODE != 0`, otherwise go to STOP.
- **PARITY**: sample the parity bit and compute the expected value.
  - Even: XOR of data bits equals the parity bit.
  - Odd: XOR of data bits differs from the parity bit.
  - Go to STOP.
- **STOP**: sample the stop bit, then return to IDLE on the same edge.
  - Stop bit 0: discard the word and set `framing_err`.
  - Stop bit 1 but parity mismatch: discard the word and set `parity_err`.
  - Stop bit 1, parity OK, FIFO not full (or popped in the same cycle): push the word.
  - Stop bit 1, parity OK, FIFO full with no pop: discard the word and set `overrun`.
- A falling-edge detector in IDLE requires a 1→0 transition. A line held low after a framing error therefore never restarts reception until it returns high.
- FIFO behaviour:
  - Simultaneous push and pop is allowed when full and when non-empty; `count` is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `err_clr` has priority below a same-cycle error set: the flag stays set.
- Reset values: state IDLE, `empty`=1, `full`=0, `count`=0, `dout`=0, all error flags 0, `busy`=0.

## Timing
- Reset mid-frame aborts immediately; the partial word is lost.
- Line-to-start-detection latency is 2 cycles (synchroniser) plus 1 cycle (edge detect).
- Each sample point falls `BAUD_CLOCKS/2 + k·BAUD_CLOCKS` cycles after start detection.
- The push takes effect on the stop-sample edge. `empty` falls and `dout` is valid the following cycle.
- `rd_en` pops on the rising edge. The new head appears on `dout` the next cycle (FWFT, registered output).
- `busy` is high from the cycle after start detection through the STOP sample cycle.

## Structure
- Package `uart_pkg` holds:
  - `parity_mode_t` enum (NONE, EVEN, ODD);
  - `rx_state_t` enum;
  - `function baud_clocks(clk_rate, baud_rate)`.
- Sub-module `sync_fifo` is parametrised on `WIDTH`, `DEPTH` and is FWFT. It has inputs `clk`, `rst`, `push`, `pop`, `din` and outputs `dout`, `empty`, `full`, `count`.
- Receiver FSM, baud counter and bit counter live in the top module.

## Test plan
- **Receive 0x5A, even parity:** 115200 baud (8680 ns/bit), parity bit 0 → `empty` falls, `dout`=0x5A, no error flags.
- **Same frame with parity bit 1:** → nothing pushed, `parity_err`=1. Then `err_clr` → `parity_err`=0.
- **Stop bit driven 0** (0x41 frame), then line returns high and 0x42 is sent → `framing_err`=1, FIFO holds only 0x42.
- **Glitch:** a 2000 ns low pulse on an idle line → state returns to IDLE, `busy` falls, FIFO stays empty.
- **Overrun:** send FIFO_DEPTH+1 frames 0x01..0x05 without reads → `full`=1, `overrun`=1. Popping yields 0x01..0x04 in order, then `empty`=1.
- **Odd parity, 7 data bits:** with `PARITY_MODE`=2, `DATA_BITS`=7, send 0x7F with parity 0 → `dout`=0x7F. Then assert `rst` mid-frame → all outputs return to reset values, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int baud_clocks(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: a push is visible on dout the next cycle; pushes
// into a full FIFO are dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a FWFT FIFO; a word appears on dout the cycle after its stop
// sample. A full FIFO drops the incoming good frame and raises the sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic                          busy
);

  localparam int BAUD_CLOCKS = baud_clocks(CLK_RATE, BAUD_RATE);
  localparam int CNT_W       = $clog2(BAUD_CLOCKS + 1);
  localparam int BIT_W       = $clog2(DATA_BITS);
  // Loads are one less than the interval because the sample happens on the zero count.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_CLOCKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CLOCKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam parity_mode_t     PMODE     = parity_mode_t'(2'(PARITY_MODE));

  rx_state_t            state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_ok_q, par_ok_d;
  logic                 pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                 pe_set, fe_set, ov_set;
  logic                 fifo_push, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    fifo_push = 1'b0;
    pe_set    = 1'b0;
    fe_set    = 1'b0;
    ov_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!sync2_q) begin
          state_d  = DATA;
          cnt_d    = FULL_LOAD;
          bit_d    = '0;
          par_ok_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == LAST_BIT) state_d = (PMODE == NONE) ? STOP : PARITY;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          par_ok_d = (PMODE == ODD) ? ((^shift_q) != sync2_q) : ((^shift_q) == sync2_q);
          cnt_d    = FULL_LOAD;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (!sync2_q)              fe_set    = 1'b1;
          else if (!par_ok_q)        pe_set    = 1'b1;
          else if (full && !rd_en)   ov_set    = 1'b1;
          else                       fifo_push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle error set wins over err_clr.
  assign pe_d = pe_set | (pe_q & ~err_clr);
  assign fe_d = fe_set | (fe_q & ~err_clr);
  assign ov_d = ov_set | (ov_q & ~err_clr);

  assign parity_err  = pe_q;
  assign framing_err = fe_q;
  assign overrun     = ov_q;
  assign busy        = (state_q != IDLE);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (shift_q),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: an 8-bit even-parity receiver and a 7-bit odd-parity receiver,
// both run at 100 clocks per bit so the whole run stays short.
module tb_uart_rx_fifo;

  localparam int CLK_RATE  = 100_000_000;
  localparam int BAUD_RATE = 1_000_000;
  localparam int BIT_NS    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rx7 = 1'b1;
  logic       rd_en = 1'b0, rd7 = 1'b0, err_clr = 1'b0;

  logic [7:0] dout;
  logic       empty, full, pe, fe, ov, busy;
  logic [2:0] count;
  logic [6:0] dout7;
  logic       empty7, full7, pe7, fe7, ov7, busy7;
  logic [2:0] count7;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp7_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx), .rd_en(rd_en), .dout(dout), .empty(empty),
    .full(full), .count(count), .parity_err(pe), .framing_err(fe), .overrun(ov),
    .err_clr(err_clr), .busy(busy)
  );

  uart_rx_fifo #(
    .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7), .PARITY_MODE(2), .FIFO_DEPTH(4)
  ) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .rd_en(rd7), .dout(dout7), .empty(empty7),
    .full(full7), .count(count7), .parity_err(pe7), .framing_err(fe7), .overrun(ov7),
    .err_clr(err_clr), .busy(busy7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx  = v;
  endtask

  task automatic send(input bit sel, input logic [8:0] data, input int nbits,
                      input bit par, input bit stopb);
    drive(sel, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      #(BIT_NS);
    end
    drive(sel, par);
    #(BIT_NS);
    drive(sel, stopb);
    #(BIT_NS);
    drive(sel, 1'b1);
  endtask

  task automatic wait_data(input string tag);
    int n = 0;
    while (empty && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(empty), 32'd0);
  endtask

  task automatic drain(input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("pop_not_empty", 32'(empty), 32'd0);
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e));
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;
    repeat (5) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flags", 32'({pe, fe, ov}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x5A has four ones, so even parity bit is 0.
    exp_q.push_back(9'h05A);
    send(1'b0, 9'h05A, 8, 1'b0, 1'b1);
    #(2 * BIT_NS);
    wait_data("t1_arrive");
    check("t1_count", 32'(count), 32'd1);
    check("t1_flags", 32'({pe, fe, ov}), 32'd0);
    drain(1);
    check("t1_empty_after", 32'(empty), 32'd1);

    send(1'b0, 9'h05A, 8, 1'b1, 1'b1);
    #(2 * BIT_NS);
    @(negedge clk);
    check("t2_parity_err", 32'(pe), 32'd1);
    check("t2_no_push", 32'(empty), 32'd1);
    clear_errors();
    check("t2_cleared", 32'(pe), 32'd0);

    send(1'b0, 9'h041, 8, 1'b0, 1'b0);
    #(2 * BIT_NS);
    check("t3_framing_err", 32'(fe), 32'd1);
    check("t3_no_push", 32'(empty), 32'd1);
    exp_q.push_back(9'h042);
    send(1'b0, 9'h042, 8, 1'b0, 1'b1);
    #(2 * BIT_NS);
    wait_data("t3_arrive");
    check("t3_count", 32'(count), 32'd1);
    drain(1);
    clear_errors();

    // Short low pulse: the start-bit midpoint sees the line high again.
    @(negedge clk);
    rx = 1'b0;
    #150;
    check("glitch_busy", 32'(busy), 32'd1);
    #50;
    rx = 1'b1;
    #(BIT_NS);
    @(negedge clk);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_empty", 32'(empty), 32'd1);
    check("glitch_flags", 32'({pe, fe, ov}), 32'd0);

    for (int v = 1; v <= 5; v++) begin
      b = 8'(v);
      if (v <= 4) exp_q.push_back({1'b0, b});
      send(1'b0, {1'b0, b}, 8, ^b, 1'b1);
      #(BIT_NS);
    end
    @(negedge clk);
    check("ovr_full", 32'(full), 32'd1);
    check("ovr_flag", 32'(ov), 32'd1);
    check("ovr_count", 32'(count), 32'd4);
    drain(4);
    check("ovr_drained", 32'(empty), 32'd1);
    check("ovr_count0", 32'(count), 32'd0);
    check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Seven ones XOR to 1, so odd parity wants a 0 parity bit.
    exp7_q.push_back(9'h07F);
    send(1'b1, 9'h07F, 7, 1'b0, 1'b1);
    #(2 * BIT_NS);
    n = 0;
    while (empty7 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("odd7_arrive", 32'(empty7), 32'd0);
    check("odd7_dout", 32'(dout7), 32'(exp7_q.pop_front()));
    check("odd7_flags", 32'({pe7, fe7, ov7}), 32'd0);

    fork
      send(1'b1, 9'h055, 7, 1'b1, 1'b1);
      begin
        #(4 * BIT_NS);
        @(negedge clk);
        check("mid_busy", 32'(busy7), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy7), 32'd0);
        check("mrst_empty", 32'(empty7), 32'd1);
        check("mrst_count", 32'(count7), 32'd0);
        check("mrst_dout", 32'(dout7), 32'd0);
        check("mrst_full", 32'(full7), 32'd0);
        check("mrst_ovr_main", 32'(ov), 32'd0);
      end
    join
    #(BIT_NS);
    rst = 1'b0;
    #(2 * BIT_NS);
    @(negedge clk);
    check("post_rst_empty", 32'(empty7), 32'd1);
    check("post_rst_busy", 32'(busy7), 32'd0);
    check("post_rst_flags", 32'({pe7, fe7, ov7}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
